m_pipe: RTL and testbench
=========================

M_PIPE -- requirements
Module: m_pipe

Interface
REQ-001 SHALL provide parameter XLEN, default 32, datapath width of pc/res/npc.
REQ-002 SHALL provide parameter OPW, default 16, width of the opinfo sideband.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port flush_i  input  1  squash all held entries (branch/trap redirect).
REQ-006 SHALL have port e_valid_i  input  1  E-side payload valid.
REQ-007 SHALL have port m_ready_o  output  1  this block can accept the E-side payload.
REQ-008 SHALL have ports pc_i, res_i, npc_i  input  XLEN each  E-side payload.
REQ-009 SHALL have ports cnd_i input 1 and opinfo_i input OPW  E-side payload.
REQ-010 SHALL have port m_valid_o  output  1  M-side payload valid.
REQ-011 SHALL have port W_ready_i  input  1  downstream accepts M-side payload.
REQ-012 SHALL have ports pc_o, res_o, npc_o (XLEN), cnd_o (1), opinfo_o (OPW)  output  held payload.
REQ-013 SHALL have port occ_o  output  2  number of valid entries (0..2).

Function
REQ-014 SHALL transfer on the input side only in a cycle where e_valid_i and m_ready_o are both 1.
REQ-015 SHALL transfer on the output side only in a cycle where m_valid_o and W_ready_i are both 1.
REQ-016 SHALL hold two storage slots: MAIN, which drives the outputs, and SKID, which is overflow.
REQ-017 SHALL drive m_ready_o directly from a flop: m_ready_o = !SKID.valid, with no combinational path from W_ready_i.
REQ-018 SHALL load an accepted payload into MAIN when MAIN is empty or MAIN drains in the same cycle, and into SKID otherwise.
REQ-019 SHALL, when MAIN drains while SKID is valid, move SKID into MAIN on that edge and clear SKID.
REQ-020 SHALL give a latency of 1 cycle: a payload accepted at edge N appears on the outputs after edge N when MAIN was empty.
REQ-021 SHALL sustain 1 transfer per cycle while W_ready_i stays 1.
REQ-022 SHALL keep all payload outputs stable while m_valid_o=1 and W_ready_i=0.
REQ-023 SHALL drive m_valid_o = MAIN.valid, and occ_o = MAIN.valid + SKID.valid.
REQ-024 SHALL preserve transfer order; no payload is dropped or duplicated except on flush.
REQ-025 SHALL, on flush_i=1, clear both valid bits at the edge and discard any payload accepted in the same cycle; flush wins over every simultaneous event.
REQ-026 SHALL reach occ_o=2 only when MAIN is full, MAIN is not draining, and an input transfer occurs.

Reset
REQ-027 SHALL clear MAIN.valid and SKID.valid on reset, giving m_valid_o=0, m_ready_o=1, occ_o=0 in the next cycle.
REQ-028 SHALL drive all payload outputs to 0 after reset.
REQ-029 SHALL, when reset is asserted mid-stall, discard both entries with no output transfer that cycle.

Configuration
REQ-030 SHALL use macro YSYX_23060251_MPIPE_SKID_EN to select the buffering scheme.
REQ-031 SHALL, with YSYX_23060251_MPIPE_SKID_EN defined, implement the behaviour of REQ-016..REQ-026.
REQ-032 SHALL, without YSYX_23060251_MPIPE_SKID_EN, implement MAIN only, with m_ready_o = !MAIN.valid || W_ready_i (combinational) and occ_o limited to 0..1; all other rules are unchanged.

Verification
REQ-033 SHALL cover: reset, then e_valid_i=1 with res_i=0x11 -> m_valid_o=1 and res_o=0x11 one cycle later, occ_o=1.
REQ-034 SHALL cover: W_ready_i held 1 while 8 back-to-back payloads pc=0x80000000+4k are sent -> 8 outputs in order, 1 per cycle, m_ready_o stays 1.
REQ-035 SHALL cover: W_ready_i=0 while 2 payloads (0xA, 0xB) are sent -> occ_o=2, m_ready_o=0 next cycle; W_ready_i=1 -> 0xA then 0xB are output, and m_ready_o=1 after the first drain.
REQ-036 SHALL cover: occ_o=2 and flush_i=1 together with e_valid_i=1 -> next cycle occ_o=0, m_valid_o=0, and the new payload never appears.
REQ-037 SHALL cover: reset asserted while occ_o=2 and W_ready_i=1 -> next cycle all outputs 0 and m_ready_o=1.
REQ-038 SHALL cover: with the macro undefined, MAIN full and W_ready_i=1 with new input -> m_ready_o=1 in the same cycle, and the new payload is output the next cycle.

Source files
------------

// File: rtl/m_pipe.sv
// E->M pipeline register with ready/valid handshake on both sides.
// Define YSYX_23060251_MPIPE_SKID_EN for the two-entry skid buffer (registered m_ready_o).
module m_pipe #(
    parameter int XLEN = 32,
    parameter int OPW  = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush_i,
    input  logic            e_valid_i,
    output logic            m_ready_o,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] res_i,
    input  logic [XLEN-1:0] npc_i,
    input  logic            cnd_i,
    input  logic [OPW-1:0]  opinfo_i,
    output logic            m_valid_o,
    input  logic            W_ready_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] res_o,
    output logic [XLEN-1:0] npc_o,
    output logic            cnd_o,
    output logic [OPW-1:0]  opinfo_o,
    output logic [1:0]      occ_o
);

    localparam int PW = 3*XLEN + 1 + OPW;

    logic [PW-1:0] in_pl;
    logic [PW-1:0] main_pl;
    logic          main_vld;
    logic          in_xfer;
    logic          out_xfer;

    assign in_pl = {pc_i, res_i, npc_i, cnd_i, opinfo_i};
    assign {pc_o, res_o, npc_o, cnd_o, opinfo_o} = main_pl;

    assign m_valid_o = main_vld;
    assign in_xfer   = e_valid_i && m_ready_o;
    assign out_xfer  = main_vld && W_ready_i;

`ifdef YSYX_23060251_MPIPE_SKID_EN
    logic          skid_vld;
    logic [PW-1:0] skid_pl;

    // Ready comes straight from the skid flop, so W_ready_i never reaches the E side.
    assign m_ready_o = !skid_vld;
    assign occ_o     = {1'b0, main_vld} + {1'b0, skid_vld};

    always_ff @(posedge clock) begin
        if (reset) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            main_pl  <= '0;
            skid_pl  <= '0;
        end else if (flush_i) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (out_xfer && skid_vld) begin
            // No input can be accepted while the skid slot is occupied.
            main_pl  <= skid_pl;
            skid_vld <= 1'b0;
        end else if (out_xfer || !main_vld) begin
            main_vld <= in_xfer;
            if (in_xfer) main_pl <= in_pl;
        end else if (in_xfer) begin
            skid_pl  <= in_pl;
            skid_vld <= 1'b1;
        end
    end
`else
    assign m_ready_o = !main_vld || W_ready_i;
    assign occ_o     = {1'b0, main_vld};

    always_ff @(posedge clock) begin
        if (reset) begin
            main_vld <= 1'b0;
            main_pl  <= '0;
        end else if (flush_i) begin
            main_vld <= 1'b0;
        end else if (out_xfer || !main_vld) begin
            main_vld <= in_xfer;
            if (in_xfer) main_pl <= in_pl;
        end
    end
`endif

endmodule

// File: tb/tb_m_pipe.sv
// Directed + pseudo-random bench for m_pipe with an in-order scoreboard queue.
module tb_m_pipe;

    localparam int XLEN = 32;
    localparam int OPW  = 16;
    localparam int PW   = 3*XLEN + 1 + OPW;

    logic            clock = 1'b0;
    logic            reset;
    logic            flush_i;
    logic            e_valid_i;
    logic            m_ready_o;
    logic [XLEN-1:0] pc_i, res_i, npc_i;
    logic            cnd_i;
    logic [OPW-1:0]  opinfo_i;
    logic            m_valid_o;
    logic            W_ready_i;
    logic [XLEN-1:0] pc_o, res_o, npc_o;
    logic            cnd_o;
    logic [OPW-1:0]  opinfo_o;
    logic [1:0]      occ_o;

    m_pipe #(.XLEN(XLEN), .OPW(OPW)) dut (
        .clock(clock), .reset(reset), .flush_i(flush_i),
        .e_valid_i(e_valid_i), .m_ready_o(m_ready_o),
        .pc_i(pc_i), .res_i(res_i), .npc_i(npc_i), .cnd_i(cnd_i), .opinfo_i(opinfo_i),
        .m_valid_o(m_valid_o), .W_ready_i(W_ready_i),
        .pc_o(pc_o), .res_o(res_o), .npc_o(npc_o), .cnd_o(cnd_o), .opinfo_o(opinfo_o),
        .occ_o(occ_o)
    );

    always #5 clock = ~clock;

    logic [PW-1:0] q[$];
    int  n_cmp  = 0;
    int  n_fail = 0;
    bit  after_rst = 1'b0;

`ifdef YSYX_23060251_MPIPE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; outputs are checked against the model before the edge.
    task automatic step(input logic ev, input logic wr, input logic fl, input logic rs,
                        input logic [XLEN-1:0] pc, input logic [XLEN-1:0] res);
        logic [PW-1:0] p;
        logic          rdy;
        @(negedge clock);
        e_valid_i = ev;
        W_ready_i = wr;
        flush_i   = fl;
        reset     = rs;
        pc_i      = pc;
        res_i     = res;
        npc_i     = pc + 32'd4;
        cnd_i     = res[0];
        opinfo_i  = res[15:0] ^ 16'h5a5a;
        p = {pc_i, res_i, npc_i, cnd_i, opinfo_i};
        #1;
        if (CAP == 2) rdy = (q.size() < 2);
        else          rdy = (q.size() == 0) || wr;
        chk("m_valid", 128'(m_valid_o), 128'(q.size() != 0));
        chk("occ", 128'(occ_o), 128'(q.size()));
        chk("m_ready", 128'(m_ready_o), 128'(rdy));
        if (q.size() != 0)
            chk("payload", 128'({pc_o, res_o, npc_o, cnd_o, opinfo_o}), 128'(q[0]));
        if (after_rst)
            chk("zero_payload", 128'({pc_o, res_o, npc_o, cnd_o, opinfo_o}), 128'(0));
        @(posedge clock);
        if (rs || fl) begin
            q.delete();
            if (rs) after_rst = 1'b1;
        end else begin
            if (wr && q.size() != 0) void'(q.pop_front());
            if (ev && rdy) begin
                q.push_back(p);
                after_rst = 1'b0;
            end
        end
    endtask

    initial begin
        reset = 1'b1; flush_i = 1'b0; e_valid_i = 1'b0; W_ready_i = 1'b0;
        pc_i = '0; res_i = '0; npc_i = '0; cnd_i = 1'b0; opinfo_i = '0;
        repeat (2) @(posedge clock);
        after_rst = 1'b1;
        step(0, 0, 0, 1, 0, 0);

        // Reset state, then single payload with 1-cycle latency
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 32'h100, 32'h11);
        step(0, 0, 0, 0, 0, 0);
        chk("res_0x11", 128'(res_o), 128'(32'h11));
        step(0, 1, 0, 0, 0, 0);

        // Back-to-back streaming with the sink always ready
        for (int k = 0; k < 8; k++)
            step(1, 1, 0, 0, 32'h80000000 + 32'(4*k), 32'(k) + 32'h200);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Stall with two payloads, then drain
        step(1, 0, 0, 0, 32'h10, 32'hA);
`ifdef YSYX_23060251_MPIPE_SKID_EN
        step(1, 0, 0, 0, 32'h14, 32'hB);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
`else
        step(1, 0, 0, 0, 32'h14, 32'hB);
        step(1, 1, 0, 0, 32'h14, 32'hB);
        step(0, 1, 0, 0, 0, 0);
`endif
        step(0, 1, 0, 0, 0, 0);

        // Flush with a full buffer and a simultaneous new payload
        step(1, 0, 0, 0, 32'h20, 32'h21);
        step(1, 0, 0, 0, 32'h24, 32'h22);
        step(1, 0, 1, 0, 32'h28, 32'hDEAD);
        step(0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 32'h30, 32'h31);
        step(1, 1, 1, 0, 32'h34, 32'hBEEF);
        step(0, 1, 0, 0, 0, 0);

        // Reset while full and the sink is ready
        step(1, 0, 0, 0, 32'h40, 32'h41);
        step(1, 0, 0, 0, 32'h44, 32'h42);
        step(0, 1, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        chk("rst_m_ready", 128'(m_ready_o), 128'(1));

        // Sink ready with MAIN full: new payload accepted in the same cycle
        step(1, 0, 0, 0, 32'h50, 32'h51);
        step(1, 1, 0, 0, 32'h54, 32'h52);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);

        // Pseudo-random traffic
        for (int i = 0; i < 60; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 15) == 0), 1'b0, $urandom, $urandom);
        repeat (3) step(0, 1, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
